read_fifo: RTL
==============

# read_fifo

Drain-side companion to the FIFO write path: on `op_start` it pops a configured number of lines from a BRAM-backed FIFO and presents them on a valid/ready stream toward the consuming compute or memory-write unit. It hides the FIFO's fixed 1-cycle read latency behind a 2-entry skid buffer, sustains one line per cycle under continuous `out_ready`, and pulses `op_done` when the last line has been handed over.

## Interface

- `DATA_WIDTH`, 512, line width in bits (one cache line)
- `clk` in 1, clock
- `reset` in 1, synchronous, active-high
- `op_start` in 1, single-cycle start pulse, sampled only in IDLE
- `configreg` in 32, `[31:16]` = read length in lines; `[15:0]` ignored
- `fifo_empty` in 1, FIFO has no readable line this cycle
- `fifo_re` out 1, pop request; data returned exactly 1 cycle later
- `fifo_rdata` in DATA_WIDTH, FIFO read data, valid the cycle after `fifo_re`
- `out_valid` out 1, `out_data` holds a line
- `out_data` out DATA_WIDTH, line presented to consumer
- `out_ready` in 1, consumer accepts when `out_valid && out_ready`
- `busy` out 1, high while in READ
- `op_done` out 1, one-cycle completion pulse
- `stall_cycles` out 32, backpressure counter (see Configuration)

## Operation

- States: IDLE, READ.
- IDLE: on `op_start`, latch `len = configreg[31:16]`, clear `issued` and `delivered` (16-bit each). If `len == 0`, stay IDLE and pulse `op_done` next cycle; else go to READ.
- `op_start` while in READ is ignored.
- READ, issue rule (combinational from registered state): `fifo_re = !fifo_empty && issued < len && (occ + inflight - pop) < 2`, where `occ` = skid entries (0..2), `inflight` = `fifo_re` of the previous cycle, `pop` = `out_valid && out_ready`.
- Each `fifo_re` increments `issued`; a cycle after each `fifo_re`, `fifo_rdata` is written into the skid buffer tail.
- `out_valid = occ != 0`; `out_data` = skid head. Each `pop` increments `delivered` and frees the head.
- Simultaneous capture and pop in the same cycle leaves `occ` unchanged; ordering is strict FIFO.
- On the pop with `delivered == len-1`: go to IDLE, pulse `op_done` the following cycle. By construction `occ` and `inflight` are then 0.
- Skid buffer never overflows; it needs no overflow check, but an assertion guards `occ + inflight <= 2`.
- `out_data` is stable while `out_valid && !out_ready`.

## Timing

- Reset values: `fifo_re` 0, `out_valid` 0, `out_data` 0, `busy` 0, `op_done` 0, `stall_cycles` 0; state IDLE; `occ` 0.
- `op_start` in cycle N with FIFO non-empty: `fifo_re` in N+1, capture at end of N+2, `out_valid` in N+3.
- Steady state with `out_ready` held high and FIFO non-empty: one line per cycle, no bubbles.
- `out_ready` low: at most 2 further pops already committed; `fifo_re` stops within 1 cycle.
- `fifo_empty` high: `fifo_re` held low; resumes the cycle `fifo_empty` falls.
- Reset mid-operation: returns to IDLE next cycle and clears the buffer. Lines already popped from the FIFO are discarded. No `op_done` is issued.

## Configuration

- `READ_FIFO_STALL_COUNT_EN` defined: `stall_cycles` clears on accepted `op_start` and increments each READ cycle with `out_valid && !out_ready`. It saturates at 2^32-1.
- Not defined: `stall_cycles` is tied to 0 and no counter logic is generated.

## Structure

- Shared package `pipearch_fifo_pkg`: `t_readstate` enum (STATE_IDLE, STATE_READ), `SKID_DEPTH = 2`, length width constant 16.
- Sub-module `read_skid_buffer`: 2-entry register FIFO with push, pop, `occ`, and head data, parameterised on DATA_WIDTH. `read_fifo` holds the FSM, counters and issue logic.

## Test plan

- Length 4, FIFO preloaded with 0xA0..0xA3, `out_ready` always 1: `fifo_re` in N+1..N+4, lines A0..A3 in N+3..N+6, `op_done` in N+7.
- Length 0: no `fifo_re`, no `out_valid`; `op_done` exactly one cycle after `op_start`.
- Length 8, `out_ready` toggling 1,0,0,1 repeating: all 8 lines delivered in order, none duplicated, and `occ + inflight` never exceeds 2. With the macro defined, `stall_cycles` equals the number of counted stall cycles.
- Length 3, FIFO empty for 5 cycles after start and then filled: `fifo_re` stays 0 while empty, and all 3 lines are delivered afterward.
- Reset asserted 2 cycles after the first `out_valid` in a length-6 run: all outputs go to reset values next cycle. A following `op_start` with length 2 delivers the next 2 FIFO lines correctly.
- Second `op_start` with length 9 while busy with length 5: it is ignored, and exactly 5 lines are delivered with one `op_done`.

Source files
------------

// File: rtl/pipearch_fifo_pkg.sv
// Shared types and constants for the FIFO read path.
package pipearch_fifo_pkg;

  typedef enum logic {
    STATE_IDLE,
    STATE_READ
  } t_readstate;

  localparam int SKID_DEPTH = 2;
  localparam int LEN_WIDTH  = 16;

endpackage

// File: rtl/read_skid_buffer.sv
// Two-entry register FIFO that absorbs lines already requested from the BRAM FIFO
// while the consumer applies backpressure.
module read_skid_buffer
  import pipearch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_data [SKID_DEPTH];
  logic [1:0]            r_occ;

  // NOTE: the two entries are ordinary flops, so they are reset with the rest of
  // the state; that is what makes out_data read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ     <= 2'd0;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          r_data[r_occ[0]] <= i_push_data;
          r_occ            <= r_occ + 2'd1;
        end
        2'b01: begin
          r_data[0] <= r_data[1];
          r_occ     <= r_occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new line lands behind whatever survives the pop.
          if (r_occ == 2'd1) begin
            r_data[0] <= i_push_data;
          end else begin
            r_data[0] <= r_data[1];
            r_data[1] <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_data[0];

endmodule

// File: rtl/read_fifo.sv
// Drains a configured number of lines from a 1-cycle-latency BRAM FIFO onto a
// valid/ready stream. Optional stall counter: define READ_FIFO_STALL_COUNT_EN.
module read_fifo
  import pipearch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  op_done,
  output logic [31:0]           stall_cycles
);

  t_readstate           r_state, w_next_state;
  logic [LEN_WIDTH-1:0] r_len, r_issued, r_delivered;
  logic                 r_inflight, r_done;
  logic [1:0]           w_occ;
  logic                 w_pop, w_start, w_last_pop;
  logic [LEN_WIDTH-1:0] w_cfg_len;
  logic                 w_unused_cfg;

  assign w_cfg_len    = configreg[31:16];
  assign w_unused_cfg = ^configreg[15:0];
  assign w_pop        = out_valid && out_ready;
  assign out_valid    = (w_occ != 2'd0);
  assign busy         = (r_state == STATE_READ);
  assign op_done      = r_done;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    fifo_re      = 1'b0;
    w_start      = 1'b0;
    w_last_pop   = 1'b0;
    unique case (r_state)
      STATE_IDLE: begin
        if (op_start) begin
          w_start = 1'b1;
          if (w_cfg_len != '0) w_next_state = STATE_READ;
        end
      end
      STATE_READ: begin
        // Only request a line when the skid buffer is certain to have room for it.
        fifo_re = !fifo_empty && (r_issued < r_len) &&
                  (({1'b0, w_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));
        if (w_pop && (r_delivered == r_len - 16'd1)) begin
          w_last_pop   = 1'b1;
          w_next_state = STATE_IDLE;
        end
      end
      default: w_next_state = STATE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= STATE_IDLE;
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_inflight <= fifo_re;
      r_done     <= (w_start && (w_cfg_len == '0)) || w_last_pop;
      if (w_start) begin
        r_len       <= w_cfg_len;
        r_issued    <= '0;
        r_delivered <= '0;
      end else begin
        if (fifo_re) r_issued    <= r_issued + 16'd1;
        if (w_pop)   r_delivered <= r_delivered + 16'd1;
      end
    end
  end

  read_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_push     (r_inflight),
    .i_push_data(fifo_rdata),
    .i_pop      (w_pop),
    .o_occ      (w_occ),
    .o_head     (out_data)
  );

  a_skid_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, w_occ} + {2'b0, r_inflight}) <= 3'd2));

`ifdef READ_FIFO_STALL_COUNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_start) begin
      r_stall_cycles <= '0;
    end else if (busy && out_valid && !out_ready && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule
